// File: rtl/vga_main.sv
// vga_main: CPU register interface and VRAM front end of the VGA text controller.
//
// An asynchronous 8-bit bus master reaches VRAM through an auto-incrementing
// pointer. It can also start a hardware clear that fills VRAM with CLEAR_VAL.
// A second, read-only VRAM port serves the display scan-out logic.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   ncs/nrd/nwr  active-low chip select / read / write strobes (asynchronous)
//   ext_address  register select (0 STATUS/CMD, 2 POINTER, 3 DATA)
//   db_in        write data from the bus master
//   db_out       read data, driven only while ncs and nrd are both low
//   wait_sig     master must hold its strobes while this is high
//   vid_addr     scan-out read address
//   vid_data     VRAM byte at vid_addr, one cycle latency
module vga_main #(
   parameter int unsigned VRAM_AW   = 11,
   parameter logic [7:0]  CLEAR_VAL = 8'h00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ncs,
   input  logic               nrd,
   input  logic               nwr,
   input  logic [3:0]         ext_address,
   input  logic [7:0]         db_in,
   output logic [7:0]         db_out,
   output logic               wait_sig,
   input  logic [VRAM_AW-1:0] vid_addr,
   output logic [7:0]         vid_data
);

   localparam int unsigned DEPTH = 1 << VRAM_AW;
   localparam int unsigned HI_W  = VRAM_AW - 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RDLAT,
      S_DONE
   } state_t;

   // Synchronizers for the asynchronous strobes
   logic [1:0] ncs_sync_q, nrd_sync_q, nwr_sync_q;
   logic       rd_act, wr_act, rd_act_q, wr_act_q;
   logic       rd_start, wr_start;

   state_t               state_q, state_d;
   logic [VRAM_AW-1:0]   ptr_q, ptr_d;
   logic                 tog_q, tog_d;
   logic                 busy_q, busy_d;
   logic [VRAM_AW-1:0]   clr_addr_q, clr_addr_d;
   logic                 done_q, done_d;
   logic [7:0]           rdata_q, rdata_d;
   logic [3:0]           addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 is_wr_q, is_wr_d;

   // Bus/clear side of the dual-port VRAM
   logic                 ram_we;
   logic [VRAM_AW-1:0]   ram_addr;
   logic [7:0]           ram_wdata;
   logic [7:0]           ram_rdata_q;
   logic [7:0]           vid_data_q;
   logic [7:0]           mem_q [DEPTH];

   logic [7:0]           ptr_hi_ext;

   assign rd_act   = ~(ncs_sync_q[1] | nrd_sync_q[1]);
   assign wr_act   = ~(ncs_sync_q[1] | nwr_sync_q[1]);
   assign rd_start = rd_act & ~rd_act_q;
   assign wr_start = wr_act & ~wr_act_q;

   assign wait_sig = ~ncs & (~nrd | ~nwr) & ~done_q;
   assign db_out   = (~ncs & ~nrd) ? rdata_q : '0;
   assign vid_data = vid_data_q;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tog_d      = tog_q;
      busy_d     = busy_q;
      clr_addr_d = clr_addr_q;
      done_d     = done_q;
      rdata_d    = rdata_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      is_wr_d    = is_wr_q;
      ram_we     = 1'b0;
      ram_addr   = ptr_q;
      ram_wdata  = wdata_q;

      ptr_hi_ext            = '0;
      ptr_hi_ext[HI_W-1:0]  = ptr_q[VRAM_AW-1:8];

      // Clear engine owns the bus-side RAM port while busy; DATA accesses
      // stall in S_EXEC, so the two never compete for it.
      if (busy_q) begin
         ram_we     = 1'b1;
         ram_addr   = clr_addr_q;
         ram_wdata  = CLEAR_VAL;
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == '1) begin
            busy_d = 1'b0;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (wr_start || rd_start) begin
               state_d = S_EXEC;
               addr_d  = ext_address;
               wdata_d = db_in;
               is_wr_d = wr_start;
               rdata_d = '0;
            end
         end
         S_EXEC: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            case (addr_q)
               4'd0: begin
                  if (is_wr_q) begin
                     // Clear command; a repeat while busy restarts from 0
                     if (wdata_q == 8'h00) begin
                        busy_d     = 1'b1;
                        clr_addr_d = '0;
                        ptr_d      = '0;
                        tog_d      = 1'b0;
                     end
                  end else begin
                     rdata_d = {6'b0, tog_q, busy_q};
                  end
               end
               4'd2: begin
                  tog_d = ~tog_q;
                  if (is_wr_q) begin
                     if (!tog_q) begin
                        ptr_d[7:0] = wdata_q;
                     end else begin
                        ptr_d[VRAM_AW-1:8] = wdata_q[HI_W-1:0];
                     end
                  end else begin
                     rdata_d = tog_q ? ptr_hi_ext : ptr_q[7:0];
                  end
               end
               4'd3: begin
                  if (busy_q) begin
                     state_d = S_EXEC;
                     done_d  = 1'b0;
                  end else begin
                     ram_addr  = ptr_q;
                     ram_wdata = wdata_q;
                     ram_we    = is_wr_q;
                     ptr_d     = ptr_q + 1'b1;
                     if (!is_wr_q) begin
                        state_d = S_RDLAT;
                        done_d  = 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
         S_RDLAT: begin
            rdata_d = ram_rdata_q;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!rd_act && !wr_act) begin
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ncs_sync_q <= '1;
         nrd_sync_q <= '1;
         nwr_sync_q <= '1;
         rd_act_q   <= 1'b0;
         wr_act_q   <= 1'b0;
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         tog_q      <= 1'b0;
         busy_q     <= 1'b0;
         clr_addr_q <= '0;
         done_q     <= 1'b0;
         rdata_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_wr_q    <= 1'b0;
      end else begin
         ncs_sync_q <= {ncs_sync_q[0], ncs};
         nrd_sync_q <= {nrd_sync_q[0], nrd};
         nwr_sync_q <= {nwr_sync_q[0], nwr};
         rd_act_q   <= rd_act;
         wr_act_q   <= wr_act;
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tog_q      <= tog_d;
         busy_q     <= busy_d;
         clr_addr_q <= clr_addr_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         is_wr_q    <= is_wr_d;
      end
   end

   // VRAM contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[ram_addr] <= ram_wdata;
      end
      ram_rdata_q <= mem_q[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vid_data_q <= '0;
      end else begin
         vid_data_q <= mem_q[vid_addr];
      end
   end

endmodule

// File: tb/tb_vga_main.sv
module tb_vga_main;

   localparam int AW    = 11;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ncs = 1'b1, nrd = 1'b1, nwr = 1'b1;
   logic [3:0]    ext_address = '0;
   logic [7:0]    db_in = '0;
   logic [7:0]    db_out;
   logic          wait_sig;
   logic [AW-1:0] vid_addr = '0;
   logic [7:0]    vid_data;

   always #5 clk = ~clk;

   vga_main #(.VRAM_AW(AW), .CLEAR_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .ncs(ncs), .nrd(nrd), .nwr(nwr),
      .ext_address(ext_address), .db_in(db_in), .db_out(db_out),
      .wait_sig(wait_sig), .vid_addr(vid_addr), .vid_data(vid_data)
   );

   int vectors = 0;
   int errors  = 0;

   // Reference model: register file semantics in plain arithmetic
   int m_vram [DEPTH];
   int m_ptr;
   bit m_tog;
   bit m_busy;

   typedef struct {
      bit         wr;
      logic [3:0] a;
      logic [7:0] d;
   } op_t;

   task automatic m_access(input bit wr, input int a, input int d, output int exp);
      exp = 0;
      if (wr) begin
         case (a)
            0: if (d == 0) begin
                  m_busy = 1; m_ptr = 0; m_tog = 0;
                  for (int i = 0; i < DEPTH; i++) m_vram[i] = 0;
               end
            2: begin
                  if (!m_tog) m_ptr = (m_ptr / 256) * 256 + d;
                  else        m_ptr = (d % 8) * 256 + (m_ptr % 256);
                  m_tog = !m_tog;
               end
            3: begin
                  m_busy = 0;  // DATA access waits for the clear to finish
                  m_vram[m_ptr] = d;
                  m_ptr = (m_ptr + 1) % DEPTH;
               end
            default: ;
         endcase
      end else begin
         case (a)
            0: exp = (m_tog ? 2 : 0) + (m_busy ? 1 : 0);
            2: begin
                  exp = m_tog ? m_ptr / 256 : m_ptr % 256;
                  m_tog = !m_tog;
               end
            3: begin
                  m_busy = 0;
                  exp = m_vram[m_ptr];
                  m_ptr = (m_ptr + 1) % DEPTH;
               end
            default: exp = 0;
         endcase
      end
   endtask

   // One bus access: reports wait_sig at assertion, cycles until wait_sig
   // dropped (-1 on timeout), db_out while strobed and db_out after release.
   task automatic do_op(input bit wr, input logic [3:0] a, input logic [7:0] d,
                        input int limit, output logic w0, output int cyc,
                        output logic [7:0] rd, output logic [7:0] after,
                        output int exp);
      @(posedge clk); #3;
      ext_address = a;
      db_in = d;
      ncs = 1'b0;
      if (wr) nwr = 1'b0; else nrd = 1'b0;
      #1 w0 = wait_sig;
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk); #1;
         if (!wait_sig) begin
            cyc = i;
            break;
         end
      end
      rd = db_out;
      #2;
      ncs = 1'b1; nrd = 1'b1; nwr = 1'b1;
      #1 after = db_out;
      repeat (4) @(posedge clk);
      m_access(wr, int'(a), int'(d), exp);
   endtask

   task automatic vid_read(input int addr, output logic [7:0] data);
      @(posedge clk); #3;
      vid_addr = AW'(addr);
      @(posedge clk); #1;
      data = vid_data;
   endtask

   task automatic test_reset();
      logic w0; int cyc; logic [7:0] rd, after; int exp;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (db_out !== 8'h00) begin errors++; $display("FAIL reset_db_out: got %h want 00", db_out); end
      vectors++;
      if (vid_data !== 8'h00) begin errors++; $display("FAIL reset_vid_data: got %h want 00", vid_data); end
      vectors++;
      if (wait_sig !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", wait_sig); end
      #2 reset = 1'b0;
      m_ptr = 0; m_tog = 0; m_busy = 0;
      do_op(1'b0, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (rd !== 8'(exp)) begin errors++; $display("FAIL reset_status: got %h want %h", rd, 8'(exp)); end
   endtask

   task automatic test_pointer_toggle();
      op_t t [6];
      logic w0; int cyc; logic [7:0] rd, after; int exp;
      t[0] = '{1'b1, 4'd2, 8'h01};
      t[1] = '{1'b1, 4'd2, 8'h01};
      t[2] = '{1'b0, 4'd2, 8'h00};
      t[3] = '{1'b0, 4'd0, 8'h00};
      t[4] = '{1'b0, 4'd2, 8'h00};
      t[5] = '{1'b0, 4'd2, 8'h00};
      for (int i = 0; i < 6; i++) begin
         do_op(t[i].wr, t[i].a, t[i].d, 8, w0, cyc, rd, after, exp);
         vectors++;
         if (w0 !== 1'b1) begin errors++; $display("FAIL ptr_wait_assert op%0d: got %b want 1", i, w0); end
         vectors++;
         if (cyc < 1 || cyc > 6) begin errors++; $display("FAIL ptr_latency op%0d: got %0d cycles want 1..6", i, cyc); end
         if (!t[i].wr) begin
            vectors++;
            if (rd !== 8'(exp)) begin errors++; $display("FAIL ptr_read op%0d: got %h want %h", i, rd, 8'(exp)); end
            vectors++;
            if (after !== 8'h00) begin errors++; $display("FAIL ptr_db_idle op%0d: got %h want 00", i, after); end
         end
      end
   endtask

   task automatic test_data_rw();
      op_t t [12];
      logic w0; int cyc; logic [7:0] rd, after; int exp;
      t[0]  = '{1'b1, 4'd3, 8'h42};
      t[1]  = '{1'b1, 4'd3, 8'h43};
      t[2]  = '{1'b0, 4'd0, 8'h00};
      t[3]  = '{1'b1, 4'd3, 8'h44};
      t[4]  = '{1'b1, 4'd2, 8'h01};
      t[5]  = '{1'b1, 4'd2, 8'h01};
      t[6]  = '{1'b0, 4'd3, 8'h00};
      t[7]  = '{1'b0, 4'd0, 8'h00};
      t[8]  = '{1'b0, 4'd3, 8'h00};
      t[9]  = '{1'b0, 4'd3, 8'h00};
      t[10] = '{1'b0, 4'd2, 8'h00};
      t[11] = '{1'b0, 4'd2, 8'h00};
      for (int i = 0; i < 12; i++) begin
         do_op(t[i].wr, t[i].a, t[i].d, 8, w0, cyc, rd, after, exp);
         vectors++;
         if (cyc < 1 || cyc > 6) begin errors++; $display("FAIL data_latency op%0d: got %0d cycles want 1..6", i, cyc); end
         if (!t[i].wr) begin
            vectors++;
            if (rd !== 8'(exp)) begin errors++; $display("FAIL data_read op%0d: got %h want %h", i, rd, 8'(exp)); end
            vectors++;
            if (after !== 8'h00) begin errors++; $display("FAIL data_db_idle op%0d: got %h want 00", i, after); end
         end
      end
   endtask

   task automatic test_clear();
      logic w0; int cyc; logic [7:0] rd, after, vd; int exp;
      do_op(1'b1, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (cyc < 1 || cyc > 6) begin errors++; $display("FAIL clr_cmd_latency: got %0d want 1..6", cyc); end
      do_op(1'b0, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (rd !== 8'(exp)) begin errors++; $display("FAIL clr_busy_status: got %h want %h", rd, 8'(exp)); end
      repeat (2100) @(posedge clk);
      m_busy = 0;
      do_op(1'b0, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (rd !== 8'(exp)) begin errors++; $display("FAIL clr_done_status: got %h want %h", rd, 8'(exp)); end
      for (int i = 0; i < DEPTH; i++) begin
         vid_read(i, vd);
         vectors++;
         if (vd !== 8'(m_vram[i])) begin errors++; $display("FAIL clr_vram[%0h]: got %h want %h", i, vd, 8'(m_vram[i])); end
      end
   endtask

   task automatic test_stall();
      logic w0; int cyc; logic [7:0] rd, after, vd; int exp;
      do_op(1'b1, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      do_op(1'b1, 4'd3, 8'h45, 3000, w0, cyc, rd, after, exp);
      vectors++;
      if (w0 !== 1'b1) begin errors++; $display("FAIL stall_wait_assert: got %b want 1", w0); end
      vectors++;
      if (cyc <= 6 || cyc > 2100) begin errors++; $display("FAIL stall_duration: got %0d cycles want 7..2100", cyc); end
      do_op(1'b0, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (rd !== 8'(exp)) begin errors++; $display("FAIL stall_status: got %h want %h", rd, 8'(exp)); end
      vid_read(0, vd);
      vectors++;
      if (vd !== 8'(m_vram[0])) begin errors++; $display("FAIL stall_vram0: got %h want %h", vd, 8'(m_vram[0])); end
      for (int i = 0; i < 2; i++) begin
         do_op(1'b0, 4'd2, 8'h00, 8, w0, cyc, rd, after, exp);
         vectors++;
         if (rd !== 8'(exp)) begin errors++; $display("FAIL stall_ptr%0d: got %h want %h", i, rd, 8'(exp)); end
      end
   endtask

   task automatic test_wrap();
      logic w0; int cyc; logic [7:0] rd, after, vd; int exp;
      if (m_tog) begin
         do_op(1'b1, 4'd2, 8'h07, 8, w0, cyc, rd, after, exp);
         do_op(1'b1, 4'd2, 8'hFF, 8, w0, cyc, rd, after, exp);
      end else begin
         do_op(1'b1, 4'd2, 8'hFF, 8, w0, cyc, rd, after, exp);
         do_op(1'b1, 4'd2, 8'h07, 8, w0, cyc, rd, after, exp);
      end
      do_op(1'b1, 4'd3, 8'hA1, 8, w0, cyc, rd, after, exp);
      do_op(1'b1, 4'd3, 8'hB2, 8, w0, cyc, rd, after, exp);
      vid_read(DEPTH - 1, vd);
      vectors++;
      if (vd !== 8'(m_vram[DEPTH-1])) begin errors++; $display("FAIL wrap_top: got %h want %h", vd, 8'(m_vram[DEPTH-1])); end
      vid_read(0, vd);
      vectors++;
      if (vd !== 8'(m_vram[0])) begin errors++; $display("FAIL wrap_zero: got %h want %h", vd, 8'(m_vram[0])); end
      for (int i = 0; i < 2; i++) begin
         do_op(1'b0, 4'd2, 8'h00, 8, w0, cyc, rd, after, exp);
         vectors++;
         if (rd !== 8'(exp)) begin errors++; $display("FAIL wrap_ptr%0d: got %h want %h", i, rd, 8'(exp)); end
      end
   endtask

   task automatic test_random();
      logic w0; int cyc; logic [7:0] rd, after, vd; int exp;
      bit wr; logic [3:0] a; logic [7:0] d; int r, va;
      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 9);
         wr = 1'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         if (r <= 3)      a = 4'd3;
         else if (r <= 5) a = 4'd2;
         else if (r == 6) a = 4'd0;
         else begin
            a = 4'($urandom_range(4, 16));
            if (a == 4'd0) a = 4'd1;
         end
         if (a == 4'd0 && wr && d == 8'h00) d = 8'h5A;  // keep clears out of this mix
         do_op(wr, a, d, 8, w0, cyc, rd, after, exp);
         vectors++;
         if (cyc < 1 || cyc > 6) begin errors++; $display("FAIL rnd_latency op%0d a=%0d: got %0d want 1..6", i, a, cyc); end
         if (!wr) begin
            vectors++;
            if (rd !== 8'(exp)) begin errors++; $display("FAIL rnd_read op%0d a=%0d: got %h want %h", i, a, rd, 8'(exp)); end
            vectors++;
            if (after !== 8'h00) begin errors++; $display("FAIL rnd_db_idle op%0d: got %h want 00", i, after); end
         end
      end
      for (int i = 0; i < 64; i++) begin
         va = (i < 8) ? (m_ptr + DEPTH - 1 - i) % DEPTH : $urandom_range(0, DEPTH - 1);
         vid_read(va, vd);
         vectors++;
         if (vd !== 8'(m_vram[va])) begin errors++; $display("FAIL rnd_vram[%0h]: got %h want %h", va, vd, 8'(m_vram[va])); end
      end
   endtask

   task automatic test_reset_mid_clear();
      logic w0; int cyc; logic [7:0] rd, after; int exp;
      do_op(1'b1, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      repeat (50) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #3 reset = 1'b0;
      m_ptr = 0; m_tog = 0; m_busy = 0;
      do_op(1'b0, 4'd0, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (rd !== 8'(exp)) begin errors++; $display("FAIL rst_mid_status: got %h want %h", rd, 8'(exp)); end
      do_op(1'b0, 4'd2, 8'h00, 8, w0, cyc, rd, after, exp);
      vectors++;
      if (rd !== 8'(exp)) begin errors++; $display("FAIL rst_mid_ptr: got %h want %h", rd, 8'(exp)); end
   endtask

   initial begin
      test_reset();
      test_pointer_toggle();
      test_data_rw();
      test_clear();
      test_stall();
      test_wrap();
      test_random();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/vga_main.md
Name: vga_main

Overview:
CPU-facing register interface and video-RAM (VRAM) front end of the ICE40UP5K VGA text controller.
- An asynchronous 8-bit bus master (active-low chip select and read/write strobes, 4-bit register address) reads and writes VRAM through an auto-incrementing pointer.
- It can trigger a hardware clear of VRAM.
- A second, read-only VRAM port serves the display scan-out logic.

Parameters:
VRAM_AW, 11, VRAM address width; VRAM depth is 2^VRAM_AW bytes (2048).
CLEAR_VAL, 8'h00, byte written to every VRAM location by the clear command.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
ncs  in  1  chip select, active low, asynchronous to clk.
nrd  in  1  read strobe, active low, asynchronous.
nwr  in  1  write strobe, active low, asynchronous.
ext_address  in  4  register select.
db_in  in  8  write data from the bus master.
db_out  out  8  read data to the bus master.
wait_sig  out  1  active high; master must hold its strobes while this is high.
vid_addr  in  VRAM_AW  scan-out read address.
vid_data  out  8  VRAM byte at vid_addr, registered with 1-cycle latency.

Behaviour:
Reset values:
- pointer = 0, byte toggle = 0, busy = 0, done = 0.
- db_out = 0, vid_data = 0.
- Synchronizers cleared to the inactive (high) level.
- VRAM contents are not reset.

Bus synchronisation:
- ncs, nrd, nwr each pass through a 2-flop synchronizer.
- A read access starts on the first cycle in which synced (ncs|nrd) goes from 1 to 0; a write access likewise on (ncs|nwr).
- ext_address and db_in are sampled on the start cycle.

wait_sig:
- Combinational: high = raw ncs low AND (raw nrd low OR raw nwr low) AND done = 0.
- done is set when the access completes.
- done is cleared when the synced strobes return inactive.
- An access completes no later than 4 cycles after start, except when stalled by a clear in progress (see below).

db_out:
- Holds the read result while raw ncs and raw nrd are both low; otherwise it is 0.

Register map (addresses 4–15 and 1: reads return 0, writes ignored):
- 0 STATUS/CMD.
  - Read: bit0 = busy (clear running), bit1 = byte toggle, other bits 0.
  - Write 8'h00: start a clear, and reset pointer and toggle to 0. Any other written value is ignored.
- 2 POINTER.
  - Write: toggle = 0 loads pointer[7:0]; toggle = 1 loads pointer[VRAM_AW-1:8] from the low bits of db_in. Toggle then flips.
  - Read: toggle = 0 returns pointer[7:0]; toggle = 1 returns the upper bits zero-extended. Toggle then flips.
  - Reads and writes share the single toggle.
- 3 DATA.
  - Write: stores db_in at VRAM[pointer], then pointer increments.
  - Read: returns VRAM[pointer] (1-cycle RAM latency, inside the completion window), then pointer increments.
  - The pointer wraps from 2^VRAM_AW-1 to 0.

Clear engine:
- While busy, writes CLEAR_VAL to addresses 0..2^VRAM_AW-1, one per cycle.
- busy clears after the last address is written.
- A DATA read or write arriving while busy stalls with wait_sig high until busy = 0, then executes.
- STATUS and POINTER accesses proceed during a clear.
- A second clear command while busy restarts the clear from address 0.

Scan-out port:
- Always served; the bus port has priority only on the bus-port side of the dual-port RAM.
- Simultaneous bus and scan-out accesses never conflict.

Reset mid-access or mid-clear: the operation is aborted and reset values apply.

Test Plan:
1. After reset, write reg2 = 01 twice -> pointer = 0x101. Read reg2 -> 01. Read reg0 -> bit1 = 1. Read reg2 -> 01. Read reg2 -> 01 (low byte again).
2. Write reg3 = 42, 43, then read reg0 (toggle 0). Write reg3 = 44. Write reg2 = 01 twice. Read reg3, reg0, reg3, reg3 -> 42, status, 43, 44; pointer ends 0x104.
3. Write reg0 = 00 -> pointer = 0. Read reg0 -> bit0 = 1. After 2048 cycles -> bit0 = 0, and all VRAM bytes (checked via vid_addr/vid_data) = 00.
4. Write reg3 = 45 immediately after clear command -> wait_sig stays high until busy drops. Then VRAM[0] = 45, pointer = 1.
5. Pointer = 0x7FF, write reg3 twice -> bytes at 0x7FF and 0x000; pointer = 1.
6. Each non-stalled access: wait_sig high at strobe assertion and low within 4 cycles after start. db_out = 0 when nrd is high.
